tl_sequence_monitor: RTL and testbench
======================================

Name: tl_sequence_monitor

Overview:
Receive-side checker for the traffic-light output bus {red, yellow, green}. Samples the light lines on a slow tick strobe and decodes them into a phase. Verifies the legal phase order and per-phase dwell time, counts completed cycles, and latches the first fault. Sits downstream of the light controller, either on-chip as a self-check or on a second die watching the pads.

Parameters:
SYNC_STAGES, 2, number of input synchronizer flops on light_in (min 2)
RED_TICKS, 32, expected RED dwell in ticks
RY_TICKS, 3, expected RED_YELLOW dwell in ticks
GREEN_TICKS, 20, expected GREEN dwell in ticks
Y_TICKS, 3, expected YELLOW dwell in ticks
TOL, 1, allowed +/- deviation on every dwell, in ticks

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-clk strobe at the controller step rate; all checks evaluate only on tick=1
light_in  in  3  {red, yellow, green} from the controller, asynchronous to clk
err_clr  in  1  synchronous clear of sticky error state
phase  out  3  decoded tracked phase: 0 OFF, 1 RED, 2 RED_YELLOW, 3 GREEN, 4 YELLOW
locked  out  1  high while the FSM is in TRACK
seq_err  out  1  sticky, set on an illegal code or an illegal order
dwell_err  out  1  sticky, set on a short or long dwell
err_code  out  3  first fault: 0 none, 1 illegal code, 2 order, 3 short, 4 long
cycle_count  out  8  completed YELLOW->RED cycles, saturating at 255
dwell  out  8  ticks spent in the current phase, saturating at 255

Behaviour:
- Reset (async, rst_n=0):
  - Synchronizer flops 0, FSM in WAIT_RED.
  - phase=0, locked=0, seq_err=0, dwell_err=0, err_code=0, cycle_count=0, dwell=0.
- light_in passes through SYNC_STAGES flops. Latency from light_in to a decision: SYNC_STAGES clk plus the next tick.
- Code map:
  - 000 OFF, 100 RED, 110 RED_YELLOW, 001 GREEN, 010 YELLOW.
  - 011, 101, 111 are illegal.
- Legal successor ring: RED->RED_YELLOW->GREEN->YELLOW->RED.
- Dwell limits: min = EXP-TOL, max = EXP+TOL, per phase.
- FSM, state changes only on tick=1 unless noted:
  - WAIT_RED:
    - code RED -> TRACK, phase=1, dwell=1.
    - Any other code -> stay, no error.
  - TRACK, code equals the current phase:
    - dwell++ (saturating).
    - When dwell reaches max+1, set dwell_err with code 4. This fires once per phase visit.
  - TRACK, code equals the legal successor:
    - If dwell < min, set dwell_err with code 3.
    - Then phase=successor, dwell=1.
    - If the successor is RED, cycle_count++ (saturating).
  - TRACK, code OFF:
    - Controller restart, no error.
    - Go to WAIT_RED, phase=0, dwell=0.
  - TRACK, illegal code:
    - Set seq_err with code 1, go to FAULT.
  - TRACK, any other legal non-successor code:
    - Set seq_err with code 2, go to FAULT.
  - FAULT:
    - locked=0. phase holds the last tracked value. dwell frozen.
    - Leave only via err_clr.
- err_clr=1 (any clk, independent of tick):
  - Clears seq_err, dwell_err and err_code.
  - From FAULT, moves to WAIT_RED with phase=0, dwell=0.
  - cycle_count is not cleared; only reset clears it.
- Simultaneous err_clr and a new fault on the same clk: the fault wins. Flags and err_code take the new fault, and the FSM goes to or stays in FAULT.
- err_code records the first fault only. It is not overwritten until cleared, even if a later fault also sets a flag.
- Dwell checks stay active on the tick that also changes phase: a short-dwell check on exit and an order check can both set flags in one tick. err_code then takes the higher-priority fault, in the order 1 > 2 > 3 > 4.
- tick=0: no state, dwell, or flag changes except err_clr and the synchronizer.
- Width rule: all dwell parameters + TOL must be < 255. Compare with an 8-bit unsigned count.

Decomposition:
- Shared package tl_pkg:
  - Phase encodings 0..4, shared with the controller.
  - Light code constants.
  - err_code enumeration.
  - Default tick constants.
- One sub-module, tl_sync: SYNC_STAGES-deep multi-bit flop synchronizer with async active-low reset.

Test Plan:
- Nominal run: RED 32, RY 3, GREEN 20, Y 3 ticks, then RED. Expect locked=1, phase 1->2->3->4->1, cycle_count=1, no flags.
- Illegal code: in GREEN, drive 101 for 1 tick. Expect seq_err=1, err_code=1, locked=0. Then err_clr=1. Expect flags 0, FSM in WAIT_RED, phase=0.
- Order violation: RED 32 ticks, then GREEN. Expect seq_err=1, err_code=2.
- Long RED of 34 ticks. Expect dwell_err set on the tick where dwell reaches 34, err_code=4, still locked. Next RY is accepted.
- Short GREEN of 18 ticks, then YELLOW. Expect dwell_err=1, err_code=3. Same scenario with err_clr asserted on the same clk as the fault: flags stay set.
- Reset mid-GREEN, with rst_n low for 1 clk. Expect all outputs 0 immediately. Then 000 followed by RED relocks, with cycle_count restarting from 0.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light controller and its sequence monitor.
// Holds phase encodings, light-bus codes, fault codes, FSM states and
// default dwell constants, plus small decode/ring helpers.
package tl_pkg;

  // Phase encodings, shared with the light controller
  localparam logic [2:0] PH_OFF    = 3'd0;
  localparam logic [2:0] PH_RED    = 3'd1;
  localparam logic [2:0] PH_RY     = 3'd2;
  localparam logic [2:0] PH_GREEN  = 3'd3;
  localparam logic [2:0] PH_YELLOW = 3'd4;

  // Light bus codes {red, yellow, green}
  localparam logic [2:0] CODE_OFF    = 3'b000;
  localparam logic [2:0] CODE_RED    = 3'b100;
  localparam logic [2:0] CODE_RY     = 3'b110;
  localparam logic [2:0] CODE_GREEN  = 3'b001;
  localparam logic [2:0] CODE_YELLOW = 3'b010;

  // Default dwell times in ticks
  localparam int unsigned DEF_RED_TICKS   = 32;
  localparam int unsigned DEF_RY_TICKS    = 3;
  localparam int unsigned DEF_GREEN_TICKS = 20;
  localparam int unsigned DEF_Y_TICKS     = 3;
  localparam int unsigned DEF_TOL         = 1;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ILLEGAL = 3'd1,
    ERR_ORDER   = 3'd2,
    ERR_SHORT   = 3'd3,
    ERR_LONG    = 3'd4
  } err_code_t;

  typedef enum logic [1:0] {
    ST_WAIT_RED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_FAULT    = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] ph;
  } decoded_t;

  // Map a light-bus code to a phase; 011, 101 and 111 are illegal
  function automatic decoded_t decode_code(input logic [2:0] code);
    decoded_t d;
    d.legal = 1'b1;
    d.ph    = PH_OFF;
    case (code)
      CODE_OFF:    d.ph = PH_OFF;
      CODE_RED:    d.ph = PH_RED;
      CODE_RY:     d.ph = PH_RY;
      CODE_GREEN:  d.ph = PH_GREEN;
      CODE_YELLOW: d.ph = PH_YELLOW;
      default:     d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Legal successor in the RED->RY->GREEN->YELLOW->RED ring
  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    case (ph)
      PH_RED:    return PH_RY;
      PH_RY:     return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tl_sync.sv
// Multi-bit flop synchronizer, STAGES deep, asynchronous active-low reset.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   d          : asynchronous input bus
//   q          : synchronized output bus
module tl_sync #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/tl_sequence_monitor.sv
// Receive-side checker for the traffic-light bus {red, yellow, green}.
// Synchronizes the lights, decodes them on each tick, checks phase order and
// per-phase dwell, counts completed YELLOW->RED cycles and latches the first
// fault until err_clr.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   tick        : one-clk step strobe; all checks happen on tick=1
//   light_in    : {red, yellow, green}, asynchronous
//   err_clr     : synchronous clear of sticky error state
//   phase       : tracked phase (0 OFF,1 RED,2 RY,3 GREEN,4 YELLOW)
//   locked      : FSM is tracking
//   seq_err     : sticky illegal-code / order fault
//   dwell_err   : sticky short / long dwell fault
//   err_code    : first fault (0 none,1 illegal,2 order,3 short,4 long)
//   cycle_count : completed cycles, saturating
//   dwell       : ticks in current phase, saturating
module tl_sequence_monitor
  import tl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RED_TICKS   = DEF_RED_TICKS,
  parameter int unsigned RY_TICKS    = DEF_RY_TICKS,
  parameter int unsigned GREEN_TICKS = DEF_GREEN_TICKS,
  parameter int unsigned Y_TICKS     = DEF_Y_TICKS,
  parameter int unsigned TOL         = DEF_TOL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] light_in,
  input  logic       err_clr,
  output logic [2:0] phase,
  output logic       locked,
  output logic       seq_err,
  output logic       dwell_err,
  output logic [2:0] err_code,
  output logic [7:0] cycle_count,
  output logic [7:0] dwell
);

  localparam logic [7:0] RED_MIN   = 8'(RED_TICKS - TOL);
  localparam logic [7:0] RED_MAX   = 8'(RED_TICKS + TOL);
  localparam logic [7:0] RY_MIN    = 8'(RY_TICKS - TOL);
  localparam logic [7:0] RY_MAX    = 8'(RY_TICKS + TOL);
  localparam logic [7:0] GREEN_MIN = 8'(GREEN_TICKS - TOL);
  localparam logic [7:0] GREEN_MAX = 8'(GREEN_TICKS + TOL);
  localparam logic [7:0] Y_MIN     = 8'(Y_TICKS - TOL);
  localparam logic [7:0] Y_MAX     = 8'(Y_TICKS + TOL);

  logic [2:0] light_s;

  tl_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (light_in),
    .q     (light_s)
  );

  mon_state_t state_q, state_n;
  logic [2:0] phase_q, phase_n;
  logic [7:0] dwell_q, dwell_n;
  logic [7:0] cyc_q, cyc_n;
  logic       seq_q, seq_n;
  logic       dwl_q, dwl_n;
  err_code_t  code_q, code_n;

  decoded_t   dec;
  logic [2:0] succ;
  logic [7:0] min_l, max_l;
  logic       is_short;
  logic       set_seq, set_dwl;
  err_code_t  fault, code_base;

  always_comb begin
    min_l = '0;
    max_l = '1;
    case (phase_q)
      PH_RED:    begin min_l = RED_MIN;   max_l = RED_MAX;   end
      PH_RY:     begin min_l = RY_MIN;    max_l = RY_MAX;    end
      PH_GREEN:  begin min_l = GREEN_MIN; max_l = GREEN_MAX; end
      PH_YELLOW: begin min_l = Y_MIN;     max_l = Y_MAX;     end
      default:   ;
    endcase
  end

  always_comb begin
    dec      = decode_code(light_s);
    succ     = next_phase(phase_q);
    is_short = (dwell_q < min_l);
    state_n  = state_q;
    phase_n  = phase_q;
    dwell_n  = dwell_q;
    cyc_n    = cyc_q;
    set_seq  = 1'b0;
    set_dwl  = 1'b0;
    fault    = ERR_NONE;

    if (tick) begin
      case (state_q)
        ST_WAIT_RED: begin
          if (dec.legal && dec.ph == PH_RED) begin
            state_n = ST_TRACK;
            phase_n = PH_RED;
            dwell_n = 8'd1;
          end
        end
        ST_TRACK: begin
          // Exit checks (illegal, order, successor) also run the short-dwell
          // check; the more severe fault is assigned last so it wins err_code.
          if (!dec.legal) begin
            set_seq = 1'b1;
            set_dwl = is_short;
            fault   = ERR_ILLEGAL;
            state_n = ST_FAULT;
          end else if (dec.ph == phase_q) begin
            if (dwell_q != 8'hFF) dwell_n = dwell_q + 8'd1;
            // dwell_q == max happens once per visit since max < 255
            if (dwell_q == max_l) begin
              set_dwl = 1'b1;
              fault   = ERR_LONG;
            end
          end else if (dec.ph == PH_OFF) begin
            state_n = ST_WAIT_RED;
            phase_n = PH_OFF;
            dwell_n = '0;
          end else if (dec.ph == succ) begin
            if (is_short) begin
              set_dwl = 1'b1;
              fault   = ERR_SHORT;
            end
            phase_n = succ;
            dwell_n = 8'd1;
            if (succ == PH_RED && cyc_q != 8'hFF) cyc_n = cyc_q + 8'd1;
          end else begin
            set_seq = 1'b1;
            set_dwl = is_short;
            fault   = ERR_ORDER;
            state_n = ST_FAULT;
          end
        end
        default: ;
      endcase
    end

    // A fault can only arise from TRACK, so leaving FAULT never collides with one
    if (err_clr && state_q == ST_FAULT) begin
      state_n = ST_WAIT_RED;
      phase_n = PH_OFF;
      dwell_n = '0;
    end

    // Clear first, then let a same-cycle fault re-set flags and code
    seq_n     = (seq_q & ~err_clr) | set_seq;
    dwl_n     = (dwl_q & ~err_clr) | set_dwl;
    code_base = err_clr ? ERR_NONE : code_q;
    code_n    = (code_base == ERR_NONE) ? fault : code_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_RED;
      phase_q <= PH_OFF;
      dwell_q <= '0;
      cyc_q   <= '0;
      seq_q   <= 1'b0;
      dwl_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      dwell_q <= dwell_n;
      cyc_q   <= cyc_n;
      seq_q   <= seq_n;
      dwl_q   <= dwl_n;
      code_q  <= code_n;
    end
  end

  assign phase       = phase_q;
  assign locked      = (state_q == ST_TRACK);
  assign seq_err     = seq_q;
  assign dwell_err   = dwl_q;
  assign err_code    = code_q;
  assign cycle_count = cyc_q;
  assign dwell       = dwell_q;

endmodule

// File: tb/tb_tl_sequence_monitor.sv
// Directed bench for tl_sequence_monitor with default parameters.
module tb_tl_sequence_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] light_in = 3'b000;
  logic       err_clr = 1'b0;
  logic [2:0] phase;
  logic       locked;
  logic       seq_err;
  logic       dwell_err;
  logic [2:0] err_code;
  logic [7:0] cycle_count;
  logic [7:0] dwell;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] RD  = 3'b100;
  localparam logic [2:0] RY  = 3'b110;
  localparam logic [2:0] GR  = 3'b001;
  localparam logic [2:0] YL  = 3'b010;
  localparam logic [2:0] BAD = 3'b101;

  always #5 clk = ~clk;

  tl_sequence_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .light_in    (light_in),
    .err_clr     (err_clr),
    .phase       (phase),
    .locked      (locked),
    .seq_err     (seq_err),
    .dwell_err   (dwell_err),
    .err_code    (err_code),
    .cycle_count (cycle_count),
    .dwell       (dwell)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a code, let the synchronizer settle, then issue one tick
  task automatic step(input logic [2:0] code, input logic clr);
    light_in = code;
    repeat (3) @(negedge clk);
    tick    = 1'b1;
    err_clr = clr;
    @(negedge clk);
    tick    = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic steps(input logic [2:0] code, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(code, 1'b0);
  endtask

  task automatic clear_only();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic check_all(input string tag, input int unsigned ph, input int unsigned lk,
                           input int unsigned se, input int unsigned de,
                           input int unsigned ec, input int unsigned cc,
                           input int unsigned dw);
    check({tag, ".phase"},  phase,       ph);
    check({tag, ".locked"}, locked,      lk);
    check({tag, ".seq"},    seq_err,     se);
    check({tag, ".dwl"},    dwell_err,   de);
    check({tag, ".code"},   err_code,    ec);
    check({tag, ".cyc"},    cycle_count, cc);
    check({tag, ".dwell"},  dwell,       dw);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal cycle
    step(OFF, 1'b0);
    check("wait_off.locked", locked, 0);
    steps(RD, 32);
    check_all("nom_red", 1, 1, 0, 0, 0, 0, 32);
    steps(RY, 3);
    check_all("nom_ry", 2, 1, 0, 0, 0, 0, 3);
    steps(GR, 20);
    check_all("nom_grn", 3, 1, 0, 0, 0, 0, 20);
    steps(YL, 3);
    check_all("nom_yel", 4, 1, 0, 0, 0, 0, 3);
    step(RD, 1'b0);
    check_all("nom_wrap", 1, 1, 0, 0, 0, 1, 1);

    // Illegal code in GREEN after a full green dwell
    steps(RD, 31);
    steps(RY, 3);
    steps(GR, 20);
    step(BAD, 1'b0);
    check_all("illegal", 3, 0, 1, 0, 1, 1, 20);
    step(GR, 1'b0);
    check("fault_hold.dwell", dwell, 20);
    clear_only();
    check_all("illegal_clr", 0, 0, 0, 0, 0, 1, 0);

    // Order violation RED -> GREEN
    steps(RD, 32);
    step(GR, 1'b0);
    check_all("order", 1, 0, 1, 0, 2, 1, 32);
    clear_only();
    check_all("order_clr", 0, 0, 0, 0, 0, 1, 0);

    // Long RED: flag when dwell reaches 34
    steps(RD, 33);
    check_all("red33", 1, 1, 0, 0, 0, 1, 33);
    step(RD, 1'b0);
    check_all("long", 1, 1, 0, 1, 4, 1, 34);
    step(RY, 1'b0);
    check_all("long_ry", 2, 1, 0, 1, 4, 1, 1);
    steps(RY, 2);
    steps(GR, 18);
    step(YL, 1'b0);
    check_all("first_kept", 4, 1, 0, 1, 4, 1, 1);
    clear_only();
    check_all("trk_clr", 4, 1, 0, 0, 0, 1, 1);
    steps(YL, 2);
    step(RD, 1'b0);
    check_all("wrap2", 1, 1, 0, 0, 0, 2, 1);

    // Short GREEN with err_clr on the same clock as the fault
    steps(RD, 31);
    steps(RY, 3);
    steps(GR, 18);
    step(YL, 1'b1);
    check_all("short_clr", 4, 1, 0, 1, 3, 2, 1);
    clear_only();

    // Reset mid-GREEN
    steps(YL, 2);
    step(RD, 1'b0);
    check("wrap3.cyc", cycle_count, 3);
    steps(RD, 31);
    steps(RY, 3);
    steps(GR, 5);
    light_in = GR;
    rst_n = 1'b0;
    #1;
    check_all("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(OFF, 1'b0);
    check("relock_off.locked", locked, 0);
    step(RD, 1'b0);
    check_all("relock", 1, 1, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
